// File: rtl/seg_pkg.sv
// seg_pkg: shared segment patterns, blank constant and output polarity helper
package seg_pkg;
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  function automatic logic [6:0] seg_pol(input logic [6:0] s, input logic active_low);
    return active_low ? ~s : s;
  endfunction
endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: display values/load from the controller and pin outputs of the scan driver
interface seg_scan_driver_if #(parameter int NUM_DIGITS = 2);
  logic [4*NUM_DIGITS-1:0] digit_val;
  logic [NUM_DIGITS-1:0] digit_en;
  logic [NUM_DIGITS-1:0] blink_en;
  logic load;
  logic [6:0] seg;
  logic [NUM_DIGITS-1:0] an;
  logic frame_done;
  modport master(output digit_val, digit_en, blink_en, load, input seg, an, frame_done);
  modport slave(input digit_val, digit_en, blink_en, load, output seg, an, frame_done);
endinterface

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-high a..g segment pattern
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb seg = SEG_TABLE[hex];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment scanner with blink, slot blanking and frame-aligned loads
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_DIV    = 25000000,
  parameter int ACTIVE_LOW   = 1
) (
  input logic clk,
  input logic reset,
  seg_scan_driver_if.slave bus
);
  localparam int SW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic AL = ACTIVE_LOW != 0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AL}};
  logic [SW-1:0] slot_q, slot_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] blink_q, blink_d;
  logic phase_q, phase_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] pend_en_q, pend_en_d, act_en_q, act_en_d;
  logic [NUM_DIGITS-1:0] pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
  logic pend_valid_q, pend_valid_d;
  logic [6:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic frame_done_q, frame_done_d;
  logic slot_end, wrap, blink_end, commit, show;
  logic [3:0] nib;
  logic [6:0] dec;
  hex_to_seg7 u_dec (.hex(nib), .seg(dec));
  always_comb begin
    nib = act_val_q[4*idx_q +: 4];
    slot_end = slot_q == SW'(REFRESH_DIV - 1);
    wrap = slot_end && idx_q == IW'(NUM_DIGITS - 1);
    blink_end = blink_q == BW'(BLINK_DIV - 1);
    slot_d = slot_end ? '0 : slot_q + 1'b1;
    idx_d = !slot_end ? idx_q : wrap ? '0 : idx_q + 1'b1;
    blink_d = blink_end ? '0 : blink_q + 1'b1;
    phase_d = phase_q ^ blink_end;
    pend_val_d = bus.load ? bus.digit_val : pend_val_q;
    pend_en_d = bus.load ? bus.digit_en : pend_en_q;
    pend_blink_d = bus.load ? bus.blink_en : pend_blink_q;
    pend_valid_d = bus.load | (pend_valid_q & ~wrap);
    commit = wrap & pend_valid_q;
    act_val_d = commit ? pend_val_q : act_val_q;
    act_en_d = commit ? pend_en_q : act_en_q;
    act_blink_d = commit ? pend_blink_q : act_blink_q;
    show = int'(slot_q) >= BLANK_CYCLES && act_en_q[idx_q] && !(act_blink_q[idx_q] && phase_q);
    seg_d = seg_pol(show ? dec : SEG_OFF, AL);
    an_d = (show ? NUM_DIGITS'(1) << idx_q : '0) ^ AN_OFF;
    frame_done_d = wrap;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
      idx_q <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      pend_val_q <= '0;
      pend_en_q <= '0;
      pend_blink_q <= '0;
      pend_valid_q <= 1'b0;
      act_val_q <= '0;
      act_en_q <= '0;
      act_blink_q <= '0;
      seg_q <= seg_pol(SEG_OFF, AL);
      an_q <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      idx_q <= idx_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      pend_val_q <= pend_val_d;
      pend_en_q <= pend_en_d;
      pend_blink_q <= pend_blink_d;
      pend_valid_q <= pend_valid_d;
      act_val_q <= act_val_d;
      act_en_q <= act_en_d;
      act_blink_q <= act_blink_d;
      seg_q <= seg_d;
      an_q <= an_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign bus.seg = seg_q;
  assign bus.an = an_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed scoreboard bench for the scan driver, active-high and active-low builds
module tb_seg_scan_driver;
  localparam int ND = 2;
  typedef struct {
    int cyc;
    bit which;
    logic [6:0] seg;
    logic [1:0] an;
    logic fd;
    string name;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int base = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [6:0] tbl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  localparam logic [6:0] S_A = 7'b1110111;
  localparam logic [6:0] S_3 = 7'b1111001;
  localparam logic [6:0] S_5 = 7'b1011011;
  localparam logic [6:0] S_2 = 7'b1101101;
  localparam logic [6:0] S_1 = 7'b0110000;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  seg_scan_driver_if #(.NUM_DIGITS(ND)) bus1 ();
  seg_scan_driver_if #(.NUM_DIGITS(ND)) bus2 ();
  seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(4), .BLANK_CYCLES(1), .BLINK_DIV(16), .ACTIVE_LOW(0))
    dut (.clk(clk), .reset(rst), .bus(bus1));
  seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(4), .BLANK_CYCLES(1), .BLINK_DIV(16), .ACTIVE_LOW(1))
    dut_al (.clk(clk), .reset(rst), .bus(bus2));
  task automatic push(input int e, input bit w, input logic [6:0] s, input logic [1:0] a, input logic f, input string n);
    exp_t x;
    x.cyc = base + e;
    x.which = w;
    x.seg = s;
    x.an = a;
    x.fd = f;
    x.name = n;
    q.push_back(x);
  endtask
  task automatic push_frame(input int b, input logic [6:0] s0, input logic [1:0] a0,
                            input logic [6:0] s1, input logic [1:0] a1, input string n);
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || i == 4) push(b + i, 0, 7'h00, 2'b00, 1'b0, n);
      else if (i < 4) push(b + i, 0, s0, a0, 1'b0, n);
      else push(b + i, 0, s1, a1, i == 7, n);
    end
  endtask
  task automatic wait_edge(input int e);
    while (cyc != base + e) @(negedge clk);
  endtask
  task automatic drive1(input logic [7:0] v, input logic [1:0] en, input logic [1:0] bl);
    bus1.digit_val = v;
    bus1.digit_en = en;
    bus1.blink_en = bl;
    bus1.load = 1'b1;
  endtask
  always @(negedge clk) begin
    exp_t x;
    logic [9:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      x = q.pop_front();
      checks++;
      act = x.which ? {bus2.seg, bus2.an, bus2.frame_done} : {bus1.seg, bus1.an, bus1.frame_done};
      if (x.cyc < cyc) begin
        errors++;
        $display("FAIL %s expectation for cycle %0d not reached in order (now %0d)", x.name, x.cyc, cyc);
      end else if (act !== {x.seg, x.an, x.fd}) begin
        errors++;
        $display("FAIL %s cyc %0d got seg=%b an=%b fd=%b want seg=%b an=%b fd=%b",
                 x.name, cyc - base, act[9:3], act[2:1], act[0], x.seg, x.an, x.fd);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    bus1.digit_val = '0; bus1.digit_en = '0; bus1.blink_en = '0; bus1.load = 1'b0;
    bus2.digit_val = '0; bus2.digit_en = '0; bus2.blink_en = '0; bus2.load = 1'b0;
    repeat (3) @(negedge clk);
    base = cyc;
    rst = 1'b0;
    drive1(8'h3A, 2'b11, 2'b00);
    push(1, 1, 7'h7F, 2'b11, 1'b0, "al_reset");
    push_frame(1, 7'h00, 2'b00, 7'h00, 2'b00, "pre_commit");
    push_frame(9, S_A, 2'b01, S_3, 2'b10, "show_3A");
    push_frame(17, S_A, 2'b01, S_3, 2'b10, "show_3A_2");
    push_frame(25, S_A, 2'b01, S_3, 2'b10, "wrap_load_old");
    push_frame(33, S_5, 2'b01, S_5, 2'b10, "wrap_load_new");
    wait_edge(1);
    bus1.load = 1'b0;
    wait_edge(23);
    drive1(8'h55, 2'b11, 2'b00);
    wait_edge(24);
    bus1.load = 1'b0;
    wait_edge(35);
    push_frame(41, S_5, 2'b01, 7'h00, 2'b00, "en01");
    push_frame(49, S_5, 2'b01, 7'h00, 2'b00, "en01_2");
    drive1(8'h55, 2'b01, 2'b00);
    wait_edge(36);
    bus1.load = 1'b0;
    wait_edge(51);
    push_frame(57, S_5, 2'b01, 7'h00, 2'b00, "blink_off_a");
    push_frame(65, S_5, 2'b01, S_5, 2'b10, "blink_on_a");
    push_frame(73, S_5, 2'b01, S_5, 2'b10, "blink_on_b");
    push_frame(81, S_5, 2'b01, 7'h00, 2'b00, "blink_off_b");
    push_frame(89, S_5, 2'b01, 7'h00, 2'b00, "blink_off_c");
    push_frame(97, S_5, 2'b01, S_5, 2'b10, "blink_on_c");
    drive1(8'h55, 2'b11, 2'b10);
    wait_edge(52);
    bus1.load = 1'b0;
    wait_edge(109);
    drive1(8'h99, 2'b11, 2'b00);
    push(112, 0, 7'h00, 2'b00, 1'b0, "mid_reset");
    wait_edge(110);
    bus1.load = 1'b0;
    wait_edge(111);
    rst = 1'b1;
    wait_edge(112);
    rst = 1'b0;
    base = cyc;
    push_frame(1, 7'h00, 2'b00, 7'h00, 2'b00, "post_reset_a");
    push_frame(9, 7'h00, 2'b00, 7'h00, 2'b00, "post_reset_b");
    push_frame(17, 7'h00, 2'b00, 7'h00, 2'b00, "post_reset_c");
    push_frame(25, S_2, 2'b01, S_1, 2'b10, "reload_12");
    wait_edge(19);
    drive1(8'h12, 2'b11, 2'b00);
    wait_edge(20);
    bus1.load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      wait_edge(27 + 8 * k);
      bus2.digit_val = {4'h0, 4'(k)};
      bus2.digit_en = 2'b01;
      bus2.blink_en = 2'b00;
      bus2.load = 1'b1;
      push(33 + 8 * k, 1, 7'h7F, 2'b11, 1'b0, "al_blank");
      push(35 + 8 * k, 1, ~tbl[k], 2'b10, 1'b0, $sformatf("al_digit_%0h", k));
      wait_edge(28 + 8 * k);
      bus2.load = 1'b0;
    end
    wait_edge(33 + 8 * 15 + 4);
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
